// File: rtl/rsv_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : rsv_dispatch_if
// Brief    : Dispatch handshake and reservation-station write bus.
// Revision : 1.0
// ============================================================================
interface rsv_dispatch_if #(
  parameter int NUM_RSV   = 4,
  parameter int PAYLOAD_W = 96
);
  logic                 valid_in;
  logic                 ready_out;
  logic [2:0]           opcode_type_in;
  logic [PAYLOAD_W-1:0] payload_in;
  logic [NUM_RSV-1:0]   rsv_free;
  logic [NUM_RSV-1:0]   rsv_valid_out;
  logic [PAYLOAD_W-1:0] payload_out;

  modport master (
    output valid_in, opcode_type_in, payload_in, rsv_free,
    input  ready_out, rsv_valid_out, payload_out
  );

  modport slave (
    input  valid_in, opcode_type_in, payload_in, rsv_free,
    output ready_out, rsv_valid_out, payload_out
  );
endinterface
`default_nettype wire

// File: rtl/rsv_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rsv_dispatch_scheduler
// Brief    : Credit-based, class-matched round-robin steering of uops to RSes.
// Revision : 1.0
// ============================================================================
module rsv_dispatch_scheduler #(
  parameter int NUM_RSV   = 4,
  parameter int RSV_DEPTH = 16,
  parameter int PAYLOAD_W = 96
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 flush,
  input  wire logic [3*NUM_RSV-1:0] rsv_type_cfg,
  rsv_dispatch_if.slave             bus,
  output logic                      err_sticky
);
  localparam int c_CRED_W = $clog2(RSV_DEPTH + 1);
  localparam int c_PTR_W  = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam logic [c_CRED_W-1:0] c_DEPTH = c_CRED_W'(RSV_DEPTH);
  localparam logic [c_CRED_W-1:0] c_ONE   = c_CRED_W'(1);

  logic [c_CRED_W-1:0]  r_credit [NUM_RSV];
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [NUM_RSV-1:0]   r_valid_out;
  logic [PAYLOAD_W-1:0] r_payload_out;
  logic                 r_err;

  logic [NUM_RSV-1:0]   w_match;
  logic [NUM_RSV-1:0]   w_elig;
  logic [NUM_RSV-1:0]   w_sel_onehot;
  logic [NUM_RSV-1:0]   w_dispatch;
  logic [NUM_RSV-1:0]   w_ovf;
  logic [c_PTR_W-1:0]   w_sel_idx;
  logic                 w_any_elig;
  logic                 w_any_match;
  logic                 w_ready;
  logic                 w_xfer;

  generate
    for (genvar i = 0; i < NUM_RSV; i++) begin : g_rsv
      assign w_match[i]    = (rsv_type_cfg[3*i +: 3] == bus.opcode_type_in);
      assign w_elig[i]     = w_match[i] && (r_credit[i] != '0);
      assign w_dispatch[i] = w_xfer && w_sel_onehot[i];
      // A free pulse against a full counter is a protocol error unless a dispatch cancels it.
      assign w_ovf[i]      = !flush && bus.rsv_free[i] && !w_dispatch[i] && (r_credit[i] == c_DEPTH);
    end
  endgenerate

  assign w_any_elig  = |w_elig;
  assign w_any_match = |w_match;
  // Unmapped classes stay acceptable so a bad uop cannot wedge dispatch.
  assign w_ready     = !flush && (w_any_elig || !w_any_match);
  assign w_xfer      = bus.valid_in && w_ready;

  // Iterating from the far end lets the nearest eligible station after rr_ptr win.
  always_comb begin
    int w_idx;
    w_idx        = 0;
    w_sel_idx    = r_rr_ptr;
    w_sel_onehot = '0;
    for (int k = NUM_RSV; k >= 1; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_RSV;
      if (w_elig[w_idx]) w_sel_idx = c_PTR_W'(w_idx);
    end
    if (w_any_elig) w_sel_onehot[w_sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RSV; i++) r_credit[i] <= c_DEPTH;
    end else if (flush) begin
      for (int i = 0; i < NUM_RSV; i++) r_credit[i] <= c_DEPTH;
    end else begin
      for (int i = 0; i < NUM_RSV; i++) begin
        if (w_dispatch[i] && !bus.rsv_free[i])
          r_credit[i] <= r_credit[i] - c_ONE;
        else if (!w_dispatch[i] && bus.rsv_free[i] && (r_credit[i] != c_DEPTH))
          r_credit[i] <= r_credit[i] + c_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= c_PTR_W'(NUM_RSV - 1);
      r_valid_out   <= '0;
      r_payload_out <= '0;
      r_err         <= 1'b0;
    end else begin
      r_valid_out <= w_xfer ? w_sel_onehot : '0;
      if (w_xfer) r_payload_out <= bus.payload_in;
      if (w_xfer && w_any_elig) r_rr_ptr <= w_sel_idx;
      if ((w_xfer && !w_any_match) || (|w_ovf)) r_err <= 1'b1;
    end
  end

  assign bus.ready_out     = w_ready;
  assign bus.rsv_valid_out = r_valid_out;
  assign bus.payload_out   = r_payload_out;
  assign err_sticky        = r_err;
endmodule
`default_nettype wire

// File: doc/rsv_dispatch_scheduler.md
Name: rsv_dispatch_scheduler

Overview:
- Sits between rename/dispatch and the bank of reservation stations (RS).
- Accepts one renamed uop per cycle and steers it to an RS whose configured class matches the uop's opcode_type.
- Tracks free entries in each RS with credit counters, stalls upstream when no eligible RS has space, and round-robins between equal-class stations.
- Output is registered, so each RS sees a clean one-hot valid_in.

Parameters:
- NUM_RSV, 4: number of reservation stations served.
- RSV_DEPTH, 16: entries per RS; credit reset value.
- PAYLOAD_W, 96: opaque uop payload width (rob entry, regs, pc, opcode, etc.).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous pipeline flush; all RSes are flushed the same cycle.
- valid_in, input, 1: uop offered by dispatch.
- ready_out, output, 1: scheduler can accept the offered uop this cycle (combinational).
- opcode_type_in, input, 3: uop class.
- payload_in, input, PAYLOAD_W: uop contents.
- rsv_type_cfg, input, 3*NUM_RSV: class of each RS; field i is bits [3i+2:3i]. Static after reset.
- rsv_free, input, NUM_RSV: pulse per RS; one entry issued or freed this cycle.
- rsv_valid_out, output, NUM_RSV: one-hot write strobe to the RSes.
- payload_out, output, PAYLOAD_W: registered payload broadcast to all RSes.
- err_sticky, output, 1: set on protocol violation; cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - credit[i] = RSV_DEPTH, rr_ptr = NUM_RSV-1.
  - rsv_valid_out = 0, payload_out = 0, err_sticky = 0.
- Eligibility:
  - elig[i] = (rsv_type_cfg field i == opcode_type_in) && (credit[i] != 0).
  - Uses registered credits only; a same-cycle rsv_free does not make an RS eligible.
- ready_out = !flush && (|elig || no RS has a matching class).
- Transfer occurs when valid_in && ready_out.
- Selection on transfer:
  - First eligible RS searching upward from (rr_ptr+1) mod NUM_RSV, wrapping.
  - rr_ptr <= selected index.
  - rr_ptr is one global pointer shared across classes.
- Output, one-cycle latency:
  - Next cycle rsv_valid_out = one-hot(selected) and payload_out = payload_in.
  - Otherwise rsv_valid_out = 0 and payload_out holds its value.
- Unmapped class (no RS configured with opcode_type_in):
  - Uop is accepted and dropped; no rsv_valid_out.
  - err_sticky <= 1.
  - This prevents upstream deadlock.
- Credits, per RS, each cycle:
  - Dispatch only: credit - 1.
  - rsv_free only: credit + 1.
  - Both: unchanged.
  - Width is clog2(RSV_DEPTH+1).
- Credit overflow: rsv_free when credit == RSV_DEPTH and no dispatch that cycle → credit saturates at RSV_DEPTH and err_sticky <= 1.
- Credit underflow cannot occur, because dispatch requires credit != 0.
- Flush (priority over everything except rst):
  - ready_out = 0 that cycle.
  - Next cycle: all credits = RSV_DEPTH, rsv_valid_out = 0, rr_ptr unchanged.
  - rsv_free on the flush cycle is ignored.
- A uop already registered on the cycle flush rises is still driven that cycle; the RSes discard it because they flush too.
- No internal FSM beyond credits and rr_ptr. Throughput is 1 uop/cycle at full occupancy of free RSes.

Test Plan:
1. Reset, then cfg = {3'd2, 3'd1, 3'd0, 3'd0} (RS0 = class 0, RS1 = class 0, RS2 = class 1, RS3 = class 2); 4 back-to-back class-0 uops with payloads 1..4 → rsv_valid_out = 0001, 0010, 0001, 0010 on cycles 1..4, payload_out matching; credit0 = credit1 = 14.
2. Fill RS2 with 16 class-1 uops, then offer a 17th → ready_out = 0, no strobe. Pulse rsv_free[2] → ready_out rises the next cycle; the uop lands on RS2 one cycle after acceptance.
3. RS2 at credit 0: the same cycle as a dispatch-blocked class-1 uop, assert rsv_free[2] → still stalled that cycle (no bypass); accepted the following cycle.
4. Simultaneous dispatch to RS3 and rsv_free[3] with credit3 = 10 → credit3 stays 10; rsv_free[0] at credit0 = 16 → credit0 stays 16 and err_sticky = 1.
5. Class-5 uop with no mapped RS → ready_out = 1, accepted, rsv_valid_out stays 0, err_sticky = 1.
6. Flush with credits {3, 7, 0, 12} and valid_in high → ready_out = 0; next cycle credits all 16 and rsv_valid_out = 0. Assert rst mid-stream → outputs clear immediately, without waiting for a clock edge.
